// File: rtl/key_gesture_pkg.sv
// key_gesture_pkg: FSM state encoding, 12 MHz timing defaults and timer sizing for key_gesture_decoder
package key_gesture_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        WAIT2     = 3'd2,
        PRESS2    = 3'd3,
        LONG_HOLD = 3'd4
    } gesture_state_e;

    localparam int DEF_FILTER_CYC = 120000;
    localparam int DEF_LONG_CYC   = 9000000;
    localparam int DEF_DOUBLE_CYC = 3600000;
    localparam int DEF_REPEAT_CYC = 1200000;

    function automatic int timer_width(input int f, input int l, input int d, input int r);
        int m;
        m = (f > l) ? f : l;
        m = (d > m) ? d : m;
        m = (r > m) ? r : m;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/key_sync_filter.sv
// key_sync_filter: 2-flop synchroniser on the active-low key plus a stability counter producing a filtered pressed level
module key_sync_filter
    import key_gesture_pkg::*;
#(
    parameter int FILTER_CYC = DEF_FILTER_CYC
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_level
);

    localparam int CW = $clog2(FILTER_CYC + 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] stable_cnt;

    // Two-flop synchroniser, released (1) out of reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= i_key_n;
            sync_2 <= sync_1;
        end
    end

    // Flip the level only after FILTER_CYC consecutive samples disagree with it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stable_cnt <= '0;
            o_level    <= 1'b0;
        end else if (sync_2 != o_level) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CW'(FILTER_CYC - 1)) begin
            stable_cnt <= '0;
            o_level    <= ~o_level;
        end else begin
            stable_cnt <= stable_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/key_gesture_decoder.sv
// key_gesture_decoder: turns one filtered key into short/long/double press pulses; auto-repeat in LONG_HOLD when KEY_GESTURE_AUTO_REPEAT_EN is defined
module key_gesture_decoder
    import key_gesture_pkg::*;
#(
    parameter int FILTER_CYC = DEF_FILTER_CYC,
    parameter int LONG_CYC   = DEF_LONG_CYC,
    parameter int DOUBLE_CYC = DEF_DOUBLE_CYC,
    parameter int REPEAT_CYC = DEF_REPEAT_CYC
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_key_n,
    output logic       o_short,
    output logic       o_long,
    output logic       o_double,
    output logic       o_repeat,
    output logic       o_held,
    output logic [2:0] o_state
);

    localparam int TW = timer_width(FILTER_CYC, LONG_CYC, DOUBLE_CYC, REPEAT_CYC);

    gesture_state_e state;
    gesture_state_e state_nxt;
    logic [TW-1:0]  timer;
    logic [TW-1:0]  timer_inc;
    logic           level;
    logic           long_hit;
    logic           gap_hit;
    logic           short_d;
    logic           long_d;
    logic           double_d;

    key_sync_filter #(
        .FILTER_CYC(FILTER_CYC)
    ) u_filter (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_key_n(i_key_n),
        .o_level(level)
    );

    assign o_held    = level;
    assign o_state   = state;
    assign timer_inc = timer + TW'(1);
    assign long_hit  = timer_inc == TW'(LONG_CYC - 1);
    assign gap_hit   = timer_inc == TW'(DOUBLE_CYC - 1);

    // State, saturating gesture timer (cleared on any state change) and registered pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            timer    <= '0;
            o_short  <= 1'b0;
            o_long   <= 1'b0;
            o_double <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= (state_nxt != state) ? '0 : (&timer) ? timer : timer_inc;
            o_short  <= short_d;
            o_long   <= long_d;
            o_double <= double_d;
        end
    end

    // Next state: a level edge always beats a coincident timeout
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = level ? PRESS1 : IDLE;
            PRESS1:    state_nxt = !level ? WAIT2 : long_hit ? LONG_HOLD : PRESS1;
            WAIT2:     state_nxt = level ? PRESS2 : gap_hit ? IDLE : WAIT2;
            PRESS2:    state_nxt = !level ? IDLE : long_hit ? LONG_HOLD : PRESS2;
            LONG_HOLD: state_nxt = !level ? IDLE : LONG_HOLD;
            default:   state_nxt = IDLE;
        endcase
    end

    // Gesture events, one per qualifying transition
    always_comb begin
        short_d  = (state == WAIT2) && !level && gap_hit;
        long_d   = (state == PRESS1) && level && long_hit;
        double_d = (state == PRESS2) && (!level || long_hit);
    end

`ifdef KEY_GESTURE_AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYC + 1);

    logic [RW-1:0] rep_cnt;
    logic          rep_run;
    logic          rep_hit;

    assign rep_run = (state == LONG_HOLD) && (state_nxt == LONG_HOLD);
    assign rep_hit = rep_cnt == RW'(REPEAT_CYC - 1);

    // Repeat tick every REPEAT_CYC cycles while staying in LONG_HOLD
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rep_cnt  <= '0;
            o_repeat <= 1'b0;
        end else begin
            rep_cnt  <= (rep_run && !rep_hit) ? rep_cnt + RW'(1) : '0;
            o_repeat <= rep_run && rep_hit;
        end
    end
`else
    assign o_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_key_gesture_decoder.sv
// tb_key_gesture_decoder: randomized gesture stimulus checked against an arithmetic timing model of the key gestures
module tb_key_gesture_decoder;

    localparam int F    = 4;
    localparam int L    = 40;
    localparam int D    = 20;
    localparam int R    = 8;
    localparam int PRE  = 2 + F;
    localparam int NLOG = 8192;
    localparam logic [3:0] EV_S = 4'b0001;
    localparam logic [3:0] EV_L = 4'b0010;
    localparam logic [3:0] EV_D = 4'b0100;
    localparam logic [3:0] EV_R = 4'b1000;
`ifdef KEY_GESTURE_AUTO_REPEAT_EN
    localparam bit AUTO_REP = 1'b1;
`else
    localparam bit AUTO_REP = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_n = 1'b1;
    logic       o_short, o_long, o_double, o_repeat, o_held;
    logic [2:0] o_state;

    int n      = 0;
    int checks = 0;
    int errors = 0;

    logic [3:0] ev_log [NLOG];
    logic [3:0] exp_ev [NLOG];
    logic [2:0] st_log [NLOG];
    logic       held_log [NLOG];
    int         pt[$];
    logic [2:0] pv[$];
    int         ht[$];
    logic       hv[$];

    key_gesture_decoder #(
        .FILTER_CYC(F),
        .LONG_CYC  (L),
        .DOUBLE_CYC(D),
        .REPEAT_CYC(R)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_key_n (key_n),
        .o_short (o_short),
        .o_long  (o_long),
        .o_double(o_double),
        .o_repeat(o_repeat),
        .o_held  (o_held),
        .o_state (o_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) n <= n + 1;

    always @(negedge clk) begin
        if (n < NLOG) begin
            ev_log[n]   = {o_repeat, o_double, o_long, o_short};
            st_log[n]   = o_state;
            held_log[n] = o_held;
        end
    end

    task automatic pst(input int t, input logic [2:0] v);
        pt.push_back(t);
        pv.push_back(v);
    endtask

    task automatic phd(input int t, input logic v);
        ht.push_back(t);
        hv.push_back(v);
    endtask

    task automatic prep(input int g, input int r);
        if (AUTO_REP)
            for (int t = g + R; t <= r; t += R) exp_ev[t] = EV_R;
    endtask

    // Expected pulses and probe points from the gesture timing rules:
    // key low at count k0 for pd1, high gd (0 = single press), low pd2.
    task automatic predict(input int k0, input int pd1, input int gd, input int pd2);
        int h1, r1, h2, r2, g, lim;
        lim = k0 + pd1 + gd + pd2 + 90;
        if (lim > NLOG) lim = NLOG;
        for (int t = k0; t < lim; t++) exp_ev[t] = 4'b0;
        pt.delete(); pv.delete(); ht.delete(); hv.delete();
        h1 = k0 + PRE;
        r1 = h1 + pd1;
        phd(h1 - 1, 1'b0); phd(h1, 1'b1); phd(r1 - 1, 1'b1); phd(r1, 1'b0);
        pst(h1, 3'd0); pst(h1 + 1, 3'd1);
        if (pd1 >= L) begin
            g = h1 + L;
            exp_ev[g] = EV_L;
            prep(g, r1);
            pst(g - 1, 3'd1); pst(g, 3'd4); pst(r1, 3'd4); pst(r1 + 1, 3'd0);
        end else if (gd == 0) begin
            exp_ev[r1 + D] = EV_S;
            pst(r1 + 1, 3'd2); pst(r1 + D - 1, 3'd2); pst(r1 + D, 3'd0);
        end else begin
            h2 = r1 + gd;
            r2 = h2 + pd2;
            phd(h2 - 1, 1'b0); phd(h2, 1'b1); phd(r2 - 1, 1'b1); phd(r2, 1'b0);
            pst(r1 + 1, 3'd2); pst(h2, 3'd2); pst(h2 + 1, 3'd3);
            if (pd2 >= L) begin
                g = h2 + L;
                exp_ev[g] = EV_D;
                prep(g, r2);
                pst(g - 1, 3'd3); pst(g, 3'd4); pst(r2 + 1, 3'd0);
            end else begin
                exp_ev[r2 + 1] = EV_D;
                pst(r2, 3'd3); pst(r2 + 1, 3'd0);
            end
        end
    endtask

    task automatic drive(input int pd1, input int gd, input int pd2, output int k0);
        k0 = n;
        key_n = 1'b0;
        repeat (pd1) @(negedge clk);
        key_n = 1'b1;
        if (gd > 0) begin
            repeat (gd) @(negedge clk);
            key_n = 1'b0;
            repeat (pd2) @(negedge clk);
            key_n = 1'b1;
        end
        repeat (60) @(negedge clk);
        predict(k0, pd1, gd, pd2);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_repeat, o_double, o_long, o_short, o_held, o_state} !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=%b", {o_repeat, o_double, o_long, o_short, o_held, o_state}, 8'b0);
        end
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if ({o_repeat, o_double, o_long, o_short, o_held, o_state} !== 8'b0) begin
            errors++;
            $display("FAIL idle_after_reset got=%b exp=%b", {o_repeat, o_double, o_long, o_short, o_held, o_state}, 8'b0);
        end
    endtask

    task automatic test_glitch;
        int k0;
        int glen [2];
        glen[0] = F - 1;
        glen[1] = $urandom_range(1, F - 1);
        foreach (glen[j]) begin
            k0 = n;
            key_n = 1'b0;
            repeat (glen[j]) @(negedge clk);
            key_n = 1'b1;
            repeat (30) @(negedge clk);
            for (int t = k0; t < n; t++) begin
                checks++;
                if ({ev_log[t], held_log[t], st_log[t]} !== 8'b0) begin
                    errors++;
                    $display("FAIL glitch len=%0d t=%0d got=%b exp=%b", glen[j], t, {ev_log[t], held_log[t], st_log[t]}, 8'b0);
                end
            end
        end
    endtask

    task automatic test_short;
        int k0;
        int pds [3];
        pds[0] = 10;
        pds[1] = $urandom_range(F, L - 2);
        pds[2] = $urandom_range(F, L - 2);
        foreach (pds[j]) begin
            drive(pds[j], 0, 0, k0);
            for (int t = k0; t < n; t++) begin
                checks++;
                if (ev_log[t] !== exp_ev[t]) begin
                    errors++;
                    $display("FAIL short_pulse pd=%0d t=%0d got=%b exp=%b", pds[j], t, ev_log[t], exp_ev[t]);
                end
            end
            foreach (pt[i]) begin
                checks++;
                if (st_log[pt[i]] !== pv[i]) begin
                    errors++;
                    $display("FAIL short_state t=%0d got=%0d exp=%0d", pt[i], st_log[pt[i]], pv[i]);
                end
            end
            foreach (ht[i]) begin
                checks++;
                if (held_log[ht[i]] !== hv[i]) begin
                    errors++;
                    $display("FAIL short_held t=%0d got=%b exp=%b", ht[i], held_log[ht[i]], hv[i]);
                end
            end
        end
    endtask

    task automatic test_double;
        int k0;
        int a [2];
        int g [2];
        int b [2];
        a[0] = 10; g[0] = 8; b[0] = 10;
        a[1] = $urandom_range(F, L - 1);
        g[1] = $urandom_range(F, D - 1);
        b[1] = $urandom_range(F, L - 1);
        foreach (a[j]) begin
            drive(a[j], g[j], b[j], k0);
            for (int t = k0; t < n; t++) begin
                checks++;
                if (ev_log[t] !== exp_ev[t]) begin
                    errors++;
                    $display("FAIL double_pulse t=%0d got=%b exp=%b", t, ev_log[t], exp_ev[t]);
                end
            end
            foreach (pt[i]) begin
                checks++;
                if (st_log[pt[i]] !== pv[i]) begin
                    errors++;
                    $display("FAIL double_state t=%0d got=%0d exp=%0d", pt[i], st_log[pt[i]], pv[i]);
                end
            end
            foreach (ht[i]) begin
                checks++;
                if (held_log[ht[i]] !== hv[i]) begin
                    errors++;
                    $display("FAIL double_held t=%0d got=%b exp=%b", ht[i], held_log[ht[i]], hv[i]);
                end
            end
        end
    endtask

    task automatic test_long;
        int k0;
        int pds [2];
        pds[0] = 100;
        pds[1] = $urandom_range(L, 90);
        foreach (pds[j]) begin
            drive(pds[j], 0, 0, k0);
            for (int t = k0; t < n; t++) begin
                checks++;
                if (ev_log[t] !== exp_ev[t]) begin
                    errors++;
                    $display("FAIL long_pulse pd=%0d t=%0d got=%b exp=%b", pds[j], t, ev_log[t], exp_ev[t]);
                end
            end
            foreach (pt[i]) begin
                checks++;
                if (st_log[pt[i]] !== pv[i]) begin
                    errors++;
                    $display("FAIL long_state t=%0d got=%0d exp=%0d", pt[i], st_log[pt[i]], pv[i]);
                end
            end
        end
    endtask

    task automatic test_edge_wins;
        int k0;
        int a [3];
        int g [3];
        int b [3];
        a[0] = 10; g[0] = D - 1; b[0] = L;
        a[1] = L - 1; g[1] = 0; b[1] = 0;
        a[2] = L; g[2] = 0; b[2] = 0;
        foreach (a[j]) begin
            drive(a[j], g[j], b[j], k0);
            for (int t = k0; t < n; t++) begin
                checks++;
                if (ev_log[t] !== exp_ev[t]) begin
                    errors++;
                    $display("FAIL edge_pulse case=%0d t=%0d got=%b exp=%b", j, t, ev_log[t], exp_ev[t]);
                end
            end
            foreach (pt[i]) begin
                checks++;
                if (st_log[pt[i]] !== pv[i]) begin
                    errors++;
                    $display("FAIL edge_state case=%0d t=%0d got=%0d exp=%0d", j, pt[i], st_log[pt[i]], pv[i]);
                end
            end
        end
    endtask

    task automatic test_random;
        int k0, kind, a, g, b;
        for (int j = 0; j < 10; j++) begin
            kind = $urandom_range(0, 2);
            a = (kind == 1) ? $urandom_range(L, 90) : $urandom_range(F, L - 1);
            g = (kind == 2) ? $urandom_range(F, D - 1) : 0;
            b = (kind == 2) ? $urandom_range(F, 70) : 0;
            drive(a, g, b, k0);
            for (int t = k0; t < n; t++) begin
                checks++;
                if (ev_log[t] !== exp_ev[t]) begin
                    errors++;
                    $display("FAIL rand_pulse a=%0d g=%0d b=%0d t=%0d got=%b exp=%b", a, g, b, t, ev_log[t], exp_ev[t]);
                end
            end
            foreach (pt[i]) begin
                checks++;
                if (st_log[pt[i]] !== pv[i]) begin
                    errors++;
                    $display("FAIL rand_state t=%0d got=%0d exp=%0d", pt[i], st_log[pt[i]], pv[i]);
                end
            end
            foreach (ht[i]) begin
                checks++;
                if (held_log[ht[i]] !== hv[i]) begin
                    errors++;
                    $display("FAIL rand_held t=%0d got=%b exp=%b", ht[i], held_log[ht[i]], hv[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int k0, d;
        k0 = n;
        key_n = 1'b0;
        repeat (PRE + 8) @(negedge clk);
        checks++;
        if (o_state !== 3'd1) begin
            errors++;
            $display("FAIL mid_press_state got=%0d exp=%0d", o_state, 1);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_repeat, o_double, o_long, o_short, o_held, o_state} !== 8'b0) begin
            errors++;
            $display("FAIL mid_reset_async got=%b exp=%b", {o_repeat, o_double, o_long, o_short, o_held, o_state}, 8'b0);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({o_repeat, o_double, o_long, o_short, o_held, o_state} !== 8'b0) begin
            errors++;
            $display("FAIL mid_reset_hold got=%b exp=%b", {o_repeat, o_double, o_long, o_short, o_held, o_state}, 8'b0);
        end
        rst_n = 1'b1;
        d = n;
        repeat (12) @(negedge clk);
        key_n = 1'b1;
        repeat (60) @(negedge clk);
        predict(d, 12, 0, 0);
        for (int t = k0; t < d; t++) exp_ev[t] = 4'b0;
        for (int t = k0; t < n; t++) begin
            checks++;
            if (ev_log[t] !== exp_ev[t]) begin
                errors++;
                $display("FAIL reset_mid_pulse t=%0d got=%b exp=%b", t, ev_log[t], exp_ev[t]);
            end
        end
        foreach (pt[i]) begin
            checks++;
            if (st_log[pt[i]] !== pv[i]) begin
                errors++;
                $display("FAIL reset_mid_state t=%0d got=%0d exp=%0d", pt[i], st_log[pt[i]], pv[i]);
            end
        end
        foreach (ht[i]) begin
            checks++;
            if (held_log[ht[i]] !== hv[i]) begin
                errors++;
                $display("FAIL reset_mid_held t=%0d got=%b exp=%b", ht[i], held_log[ht[i]], hv[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_short();
        test_double();
        test_long();
        test_edge_wins();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
